// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential PC generation, one-cycle memory response capture and a DEPTH-entry {pc, instr} FIFO.
// Optional performance counters are compiled in with IFETCH_QUEUE_PERF_EN.
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_instr
`ifdef IFETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   fetch_pc_r;
    logic          inflight_r;
    logic [31:0]   inflight_pc_r;
    logic [31:0]   pc_mem_r    [DEPTH];
    logic [31:0]   instr_mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          pop_s;
    logic          push_s;
    logic [CW:0]   occupancy_s;
    logic          redirect_lsb_unused_s;

    assign redirect_lsb_unused_s = ^redirect_pc[1:0];

    // Handshake, request gating and head-of-queue presentation.
    always_comb begin
        out_valid   = (!reset) && (count_r != {CW{1'b0}});
        pop_s       = out_valid && out_ready;
        // A response is only accepted if no redirect kills it this cycle.
        push_s      = inflight_r && !redirect;
        // Slots already promised: stored entries plus the pending response, minus the one leaving now.
        occupancy_s = (CW+1)'(count_r) + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
        imem_req    = (!reset) && (!redirect) && (occupancy_s < (CW+1)'(DEPTH));
        imem_addr   = fetch_pc_r[IMEM_AW+1:2];
        if (out_valid) begin
            out_pc    = pc_mem_r[rd_ptr_r];
            out_instr = instr_mem_r[rd_ptr_r];
        end else begin
            out_pc    = 32'h0000_0000;
            out_instr = 32'h0000_0000;
        end
    end

    // Fetch PC, inflight tracking and FIFO storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC_ALIGNED;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
        end else if (redirect) begin
            // A coincident pop has already been taken by decode; everything else is dropped.
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            inflight_r    <= 1'b0;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
        end else begin
            if (imem_req) begin
                fetch_pc_r    <= fetch_pc_r + 32'd4;
                inflight_r    <= 1'b1;
                inflight_pc_r <= fetch_pc_r;
            end else begin
                inflight_r    <= 1'b0;
            end
            if (push_s) begin
                pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
                instr_mem_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r              <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

`ifdef IFETCH_QUEUE_PERF_EN
    // Delivered-instruction and empty-output cycle counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= 32'h0000_0000;
            perf_stall_cnt <= 32'h0000_0000;
        end else begin
            if (pop_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (!out_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset; bits [1:0] shall be 0.
REQ-002 Parameter DEPTH, default 4: instruction queue entries; power of two, >= 2.
REQ-003 Parameter IMEM_AW, default 9: instruction memory word-address width.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 redirect  in  1  control-flow change; flushes the queue.
REQ-007 redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-008 imem_req  out  1  memory read request this cycle.
REQ-009 imem_addr  out  IMEM_AW  word address, fetch_pc[IMEM_AW+1:2].
REQ-010 imem_rdata  in  32  read data, valid exactly one cycle after imem_req.
REQ-011 out_valid  out  1  queue head holds a valid instruction.
REQ-012 out_ready  in  1  decode accepts the head.
REQ-013 out_pc  out  32  PC of the head instruction.
REQ-014 out_instr  out  32  head instruction word.

Function
REQ-015 The block shall hold fetch_pc, a 1-bit inflight flag with the captured request PC, and a DEPTH-entry FIFO of {pc, instr}.
REQ-016 pop = out_valid && out_ready; it removes the head at the clock edge.
REQ-017 imem_req shall be asserted iff !reset && !redirect && (count + inflight - pop) < DEPTH.
REQ-018 On imem_req: fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); inflight <= 1 with PC captured; otherwise inflight <= 0.
REQ-019 The cycle after a non-killed request, {captured PC, imem_rdata} shall be pushed; out_valid rises the following cycle. Request-to-out_valid latency is 2 cycles.
REQ-020 Push and pop in the same cycle shall leave count unchanged and preserve order; push when full shall never occur, because REQ-017 guarantees it.
REQ-021 out_valid = (count != 0); out_pc and out_instr shall show the head entry and read 0 when the queue is empty.
REQ-022 On redirect: the FIFO is emptied, fetch_pc <= {redirect_pc[31:2], 2'b00}, and any response from the current inflight request is discarded.
REQ-023 A pop coinciding with redirect shall complete (decode keeps the instruction); all other entries are discarded.
REQ-024 Redirect-to-out_valid latency shall be 3 cycles: no request in cycle N, request at the new PC in N+1, push in N+2, out_valid in N+3.
REQ-025 Back-to-back redirects: the last one wins; no stale instruction shall ever reach the output.
REQ-026 With out_ready held high and no redirect, one instruction per cycle shall be delivered in steady state.

Reset
REQ-027 While reset is high:
- fetch_pc = RESET_PC
- count = 0, inflight = 0
- imem_req = 0, out_valid = 0, out_pc = 0, out_instr = 0
- perf counters, when present, = 0
REQ-028 Reset shall take priority over redirect and over any inflight response; a response arriving during or right after reset shall be dropped.
REQ-029 The first request shall be issued to RESET_PC in the first cycle reset is low.

Configuration
REQ-030 Macro IFETCH_QUEUE_PERF_EN: when defined, add two outputs:
- perf_fetch_cnt (32 bits): increments on each pop.
- perf_stall_cnt (32 bits): increments on each cycle with !out_valid && !reset.
- Both wrap at 2^32 and are cleared by reset.
REQ-031 Without IFETCH_QUEUE_PERF_EN the ports and counters shall not exist; all other behaviour is identical.

Verification
REQ-032 Reset release, RESET_PC=0x96 masked to 0x94, imem returns addr-based data, out_ready=1 -> out_valid first in cycle 2 after release, out_pc sequence 0x94, 0x98, 0x9C.
REQ-033 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req=0; count=4; releasing out_ready delivers 4 entries in order with no loss or duplication.
REQ-034 Redirect to 0x200 while the queue holds 3 entries and one request is inflight -> no instruction with pc != 0x200 appears after the flush; out_pc=0x200 arrives 3 cycles later.
REQ-035 Redirect coinciding with a pop of pc 0x40 -> 0x40 accepted exactly once; next delivered pc = redirect target.
REQ-036 fetch_pc=0xFFFF_FFF8, out_ready=1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 With IFETCH_QUEUE_PERF_EN, 20 cycles after reset with 15 pops -> perf_fetch_cnt=15, perf_stall_cnt = number of cycles with out_valid=0.
